kb_scan_ctrl: RTL and testbench
===============================

# kb_scan_ctrl

Matrix-keyboard scan controller for the 5-row × 4-column key array on the lab board. It drives the K_ROW lines one row at a time, samples the K_COL return lines, debounces, and reports a single debounced key code with a one-cycle strobe. The downstream Display path consumes `key_code` and `press_cnt` as hex digits. It replaces the static K_ROW tie-off used in earlier labs.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clk cycles per row dwell (1 ms at 100 MHz); legal range ≥ 4.
- `DEBOUNCE_CNT`, default 20: consecutive matching dwell samples required for press or release; legal range ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `K_COL`  in  4  column returns; asynchronous, active-low, pulled up.
- `K_ROW`  out  5  row drives; active-low, exactly one bit low at any time.
- `key_code`  out  5  last debounced key, `row*4 + col` (0..19).
- `key_valid`  out  1  one-cycle strobe when `key_code` updates.
- `key_held`  out  1  high while the reported key is still pressed.
- `press_cnt`  out  8  count of accepted presses; wraps 255→0.

## Operation
- K_COL passes through a 2-flop synchronizer before any use.
- Dwell counter `dc` counts 0..SCAN_DIV-1 and wraps.
  - A sample is taken when `dc == SCAN_DIV-1`.
  - `dc` runs in every state except PRESSED, where it holds.
- Sample classification:
  - Exactly one bit of the synchronized K_COL is low: single, with `col` = index of that bit.
  - No bit low: none.
  - More than one bit low: multi, treated as none.
- State machine:
  - SCAN. On a sample: single → latch candidate `{r, col}`, set `db = 1`, go to DEBOUNCE with the row held. None → advance `r` (4 wraps to 0) and stay in SCAN.
  - DEBOUNCE. On a sample: single with the same col → `db++`. When `db` reaches DEBOUNCE_CNT, go to PRESSED. Anything else → advance `r`, go to SCAN.
  - PRESSED (exactly one cycle):
    - `key_code` ← candidate.
    - `key_valid` = 1.
    - `press_cnt++`.
    - Go to HOLD with `rc = 0`.
  - HOLD. On a sample: candidate col bit high → `rc++`; candidate col bit low → `rc = 0`. Other columns are ignored. When `rc` reaches DEBOUNCE_CNT, advance `r` and go to SCAN.
- K_ROW is registered: `~(5'b1 << r)`.
- `key_held` = 1 in PRESSED and HOLD, 0 otherwise.
- `key_code` holds its last value until the next PRESSED.
- Reset values: `K_ROW = 5'b11110`, `r = 0`, state = SCAN, `dc`/`db`/`rc` = 0, `key_code = 0`, `key_valid = 0`, `key_held = 0`, `press_cnt = 0`. Reset mid-debounce or mid-hold aborts without a strobe.

## Timing
- Synchronizer latency: 2 cycles. A column change must be stable 2 cycles before the sample edge to be seen.
- `key_valid` rises exactly 1 cycle after the sample edge at which `db` reaches DEBOUNCE_CNT.
  - With a clean press, this is (DEBOUNCE_CNT-1)·SCAN_DIV + 1 cycles after the first matching sample.
- `key_held` rises with `key_valid` and falls 1 cycle after the DEBOUNCE_CNT-th consecutive released sample.
- A row change takes effect the cycle after the advancing sample. There is a full dwell of settle time before that row is sampled.
- Simultaneous events: a second key on another row during HOLD is not seen, because the row is held. After release, scanning resumes at `r+1`.
- Full cycle with no key: 5·SCAN_DIV cycles.

## Structure
- Package `kb_pkg` holds:
  - `kb_state_t` enum: SCAN, DEBOUNCE, PRESSED, HOLD.
  - Constants `KB_NROW = 5`, `KB_NCOL = 4`, `KB_CODE_W = 5`.
  - Function `kb_col_onehot(col_n) -> {single, col}`.
- Sub-module `kb_sync`: 2-flop synchronizer, parameterized width, with async active-low reset to all-ones.
- FSM, dwell counter and output registers live in `kb_scan_ctrl`.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_CNT=3.
- Idle, no keys, for 40 cycles → K_ROW cycles 11110→11101→11011→10111→01111→11110 every 4 cycles; `key_valid` never asserts.
- Key row 2 col 1 held clean → `key_valid` pulses once with `key_code = 9`; `key_held = 1`; `press_cnt = 1`; K_ROW stays 11011 until release.
- Same key bounces (low, high, low, low, low on consecutive row-2 samples) → no strobe on the first attempt. After re-arrival on row 2, 3 clean samples give `key_code = 9`.
- Two columns low together on row 0 → treated as none; no strobe; scanning continues.
- Release while held: key high for 2 samples, then low 1, then high 3 → `key_held` stays 1 until the 3rd consecutive high sample, then 0. No second strobe.
- `rst_n` asserted mid-DEBOUNCE and again after 256 presses → all outputs return to reset values. `press_cnt` wrap is checked 255→0 before reset.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared types, constants and column-decode helpers for the matrix keyboard scanner.
package kb_pkg;

    localparam int KB_NROW   = 5;
    localparam int KB_NCOL   = 4;
    localparam int KB_CODE_W = 5;
    localparam int KB_ROW_W  = 3;
    localparam int KB_COL_W  = 2;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        HOLD     = 2'd3
    } kb_state_t;

    // Returns {single, col}; single is set only when exactly one return line is low.
    function automatic logic [KB_COL_W:0] kb_col_onehot(input logic [KB_NCOL-1:0] col_n);
        logic [KB_COL_W:0] res;
        res = {1'b0, 2'd0};
        case (col_n)
            4'b1110: res = {1'b1, 2'd0};
            4'b1101: res = {1'b1, 2'd1};
            4'b1011: res = {1'b1, 2'd2};
            4'b0111: res = {1'b1, 2'd3};
            default: res = {1'b0, 2'd0};
        endcase
        return res;
    endfunction

    function automatic logic [KB_ROW_W-1:0] kb_next_row(input logic [KB_ROW_W-1:0] row);
        logic [KB_ROW_W-1:0] nxt;
        if (row == 3'(KB_NROW - 1)) begin
            nxt = 3'd0;
        end else begin
            nxt = row + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/kb_sync.sv
// Two-flop synchronizer for asynchronous, pulled-up inputs; resets to the idle (all-ones) level.
module kb_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b1}};
            sync_r <= {WIDTH{1'b1}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/kb_scan_ctrl.sv
// Matrix keyboard scanner: drives one row low at a time, debounces press and release,
// and reports the accepted key with a one-cycle strobe and a press counter.
module kb_scan_ctrl
    import kb_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [KB_NCOL-1:0]   K_COL,
    output logic [KB_NROW-1:0]   K_ROW,
    output logic [KB_CODE_W-1:0] key_code,
    output logic                 key_valid,
    output logic                 key_held,
    output logic [7:0]           press_cnt
);

    localparam int              DC_W    = $clog2(SCAN_DIV);
    localparam int              DB_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE_CNT);

    logic [KB_NCOL-1:0]   col_sync_s;
    logic [KB_COL_W:0]    onehot_s;
    logic                 single_s;
    logic [KB_COL_W-1:0]  col_s;
    logic                 sample_s;

    kb_state_t            state_r, state_nxt_s;
    logic [KB_ROW_W-1:0]  row_r, row_nxt_s;
    logic [KB_COL_W-1:0]  cand_col_r, cand_col_nxt_s;
    logic [DC_W-1:0]      dc_r, dc_nxt_s;
    logic [DB_W-1:0]      db_r, db_nxt_s, db_inc_s;
    logic [DB_W-1:0]      rc_r, rc_nxt_s, rc_inc_s;

    logic [KB_NROW-1:0]   k_row_r;
    logic [KB_CODE_W-1:0] key_code_r;
    logic                 key_valid_r;
    logic                 key_held_r;
    logic [7:0]           press_cnt_r;

    kb_sync #(.WIDTH(KB_NCOL)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (K_COL),
        .q     (col_sync_s)
    );

    assign onehot_s = kb_col_onehot(col_sync_s);
    assign single_s = onehot_s[KB_COL_W];
    assign col_s    = onehot_s[KB_COL_W-1:0];
    assign sample_s = (dc_r == DC_LAST);
    assign db_inc_s = db_r + DB_W'(1);
    assign rc_inc_s = rc_r + DB_W'(1);

    // Dwell counter freezes during the single PRESSED cycle so HOLD starts a fresh dwell.
    always_comb begin
        dc_nxt_s = dc_r;
        if (state_r == PRESSED) begin
            dc_nxt_s = dc_r;
        end else if (sample_s) begin
            dc_nxt_s = {DC_W{1'b0}};
        end else begin
            dc_nxt_s = dc_r + DC_W'(1);
        end
    end

    // Next-state logic for scan, press debounce and release debounce.
    always_comb begin
        state_nxt_s    = state_r;
        row_nxt_s      = row_r;
        cand_col_nxt_s = cand_col_r;
        db_nxt_s       = db_r;
        rc_nxt_s       = rc_r;
        case (state_r)
            SCAN: begin
                if (sample_s && single_s) begin
                    cand_col_nxt_s = col_s;
                    db_nxt_s       = DB_W'(1);
                    state_nxt_s    = DEBOUNCE;
                end else if (sample_s) begin
                    row_nxt_s = kb_next_row(row_r);
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            DEBOUNCE: begin
                if (sample_s && single_s && (col_s == cand_col_r)) begin
                    db_nxt_s = db_inc_s;
                    if (db_inc_s == DB_DONE) begin
                        state_nxt_s = PRESSED;
                    end else begin
                        state_nxt_s = DEBOUNCE;
                    end
                end else if (sample_s) begin
                    db_nxt_s    = {DB_W{1'b0}};
                    row_nxt_s   = kb_next_row(row_r);
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = DEBOUNCE;
                end
            end
            PRESSED: begin
                rc_nxt_s    = {DB_W{1'b0}};
                state_nxt_s = HOLD;
            end
            HOLD: begin
                // Only the candidate's column matters; the row stays parked on the held key.
                if (sample_s && col_sync_s[cand_col_r]) begin
                    if (rc_inc_s == DB_DONE) begin
                        rc_nxt_s    = {DB_W{1'b0}};
                        row_nxt_s   = kb_next_row(row_r);
                        state_nxt_s = SCAN;
                    end else begin
                        rc_nxt_s    = rc_inc_s;
                        state_nxt_s = HOLD;
                    end
                end else if (sample_s) begin
                    rc_nxt_s = {DB_W{1'b0}};
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = SCAN;
                row_nxt_s   = 3'd0;
                db_nxt_s    = {DB_W{1'b0}};
                rc_nxt_s    = {DB_W{1'b0}};
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= SCAN;
            row_r      <= 3'd0;
            cand_col_r <= 2'd0;
            dc_r       <= {DC_W{1'b0}};
            db_r       <= {DB_W{1'b0}};
            rc_r       <= {DB_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            row_r      <= row_nxt_s;
            cand_col_r <= cand_col_nxt_s;
            dc_r       <= dc_nxt_s;
            db_r       <= db_nxt_s;
            rc_r       <= rc_nxt_s;
        end
    end

    // Registered outputs, each lagging the control state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_row_r     <= 5'b11110;
            key_code_r  <= 5'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
            press_cnt_r <= 8'd0;
        end else begin
            k_row_r     <= ~(5'b00001 << row_r);
            key_valid_r <= (state_r == PRESSED);
            key_held_r  <= (state_r == PRESSED) || (state_r == HOLD);
            if (state_r == PRESSED) begin
                key_code_r  <= {row_r, cand_col_r};
                press_cnt_r <= press_cnt_r + 8'd1;
            end else begin
                key_code_r  <= key_code_r;
                press_cnt_r <= press_cnt_r;
            end
        end
    end

    assign K_ROW     = k_row_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;
    assign press_cnt = press_cnt_r;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Self-checking bench for kb_scan_ctrl: a physical key-matrix model drives K_COL from K_ROW,
// and a sample-level reference model predicts every output on every cycle.
module tb_kb_scan_ctrl;

    localparam int SD  = 4;
    localparam int DBN = 3;

    localparam int P_SCAN = 0;
    localparam int P_DEB  = 1;
    localparam int P_STRB = 2;
    localparam int P_HOLD = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] k_col;
    logic [4:0] k_row;
    logic [4:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [7:0] press_cnt;

    kb_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DBN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .K_COL     (k_col),
        .K_ROW     (k_row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .press_cnt (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_strobe = 0;

    // physical key matrix: keys[row*4+col] = 1 while pressed
    logic [19:0] keys;
    int          pat_key = -1;
    bit          pat_q[$];

    // reference model state
    logic [3:0] m_s1, m_s2;
    int         m_phase, m_dc, m_row, m_cand, m_run, m_smp_row;
    logic [4:0] e_row, e_code;
    logic       e_valid, e_held;
    logic [7:0] e_cnt;

    localparam logic [19:0] RST_VEC = {5'b11110, 1'b0, 1'b0, 5'd0, 8'd0};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_phase = P_SCAN; m_dc = 0; m_row = 0; m_cand = 0; m_run = 0; m_smp_row = -1;
        e_row = 5'b11110; e_code = 5'd0; e_valid = 1'b0; e_held = 1'b0; e_cnt = 8'd0;
    endtask

    // One clock edge of the reference; col_in is the K_COL level present just before the edge.
    task automatic model_edge(input logic [3:0] col_in);
        logic [3:0] seen;
        bit smp;
        int nlow, lowcol;
        seen = m_s2;
        smp = (m_phase != P_STRB) && (m_dc == SD - 1);
        nlow = 0; lowcol = 0;
        for (int c = 0; c < 4; c++) begin
            if (!seen[c]) begin nlow++; lowcol = c; end
        end
        e_row   = 5'b11111 ^ (5'b00001 << m_row);
        e_valid = (m_phase == P_STRB);
        e_held  = (m_phase == P_STRB) || (m_phase == P_HOLD);
        if (m_phase == P_STRB) begin
            e_code = 5'(m_row * 4 + m_cand);
            e_cnt  = 8'((int'(e_cnt) + 1) % 256);
        end
        m_smp_row = smp ? m_row : -1;
        if (m_phase != P_STRB) m_dc = (m_dc + 1) % SD;
        m_s2 = m_s1;
        m_s1 = col_in;
        if (m_phase == P_STRB) begin
            m_phase = P_HOLD; m_run = 0;
        end else if (smp) begin
            if (m_phase == P_SCAN) begin
                if (nlow == 1) begin m_cand = lowcol; m_run = 1; m_phase = P_DEB; end
                else m_row = (m_row + 1) % 5;
            end else if (m_phase == P_DEB) begin
                if (nlow == 1 && lowcol == m_cand) begin
                    m_run++;
                    if (m_run == DBN) m_phase = P_STRB;
                end else begin
                    m_row = (m_row + 1) % 5; m_phase = P_SCAN;
                end
            end else begin
                if (seen[m_cand]) m_run++;
                else m_run = 0;
                if (m_run == DBN) begin m_row = (m_row + 1) % 5; m_phase = P_SCAN; end
            end
        end
    endtask

    task automatic drive_cols();
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 5; r++) begin
            if (!k_row[r]) begin
                for (int j = 0; j < 4; j++) if (keys[r * 4 + j]) c[j] = 1'b0;
            end
        end
        k_col = c;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge(k_col);
        else model_reset();
        #1;
        check_eq("outputs", {12'd0, k_row, key_valid, key_held, key_code, press_cnt},
                 {12'd0, e_row, e_valid, e_held, e_code, e_cnt});
        if (key_valid) n_strobe++;
        if (pat_key >= 0 && m_smp_row == pat_key / 4 && pat_q.size() > 0)
            keys[pat_key] = pat_q.pop_front();
        drive_cols();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("async_reset", {12'd0, k_row, key_valid, key_held, key_code, press_cnt},
                 {12'd0, RST_VEC});
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (key_valid) ok = 1'b1;
        end
        check_eq("wait_valid", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_release(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (!key_held) ok = 1'b1;
        end
        check_eq("wait_release", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, held_len, k;
        bit reached;
        rst_n = 1'b0;
        keys  = 20'd0;
        k_col = 4'hF;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;

        // idle scan
        s0 = n_strobe;
        repeat (40) step();
        check_eq("idle_strobes", n_strobe - s0, 32'd0);

        // clean press of row 2 col 1
        keys[9] = 1'b1;
        wait_valid(100);
        check_eq("code9", {27'd0, key_code}, 32'd9);
        check_eq("held9", {31'd0, key_held}, 32'd1);
        check_eq("cnt1", {24'd0, press_cnt}, 32'd1);
        repeat (12) step();
        check_eq("row_parked", {27'd0, k_row}, {27'd0, 5'b11011});
        keys[9] = 1'b0;
        wait_release(100);

        // bounce on row 2: pressed, released, pressed, pressed, pressed
        s0 = n_strobe;
        keys[9] = 1'b1;
        pat_key = 9;
        pat_q = '{1'b0, 1'b1, 1'b1, 1'b1};
        wait_valid(200);
        check_eq("bounce_strobes", n_strobe - s0, 32'd1);
        check_eq("bounce_code", {27'd0, key_code}, 32'd9);
        pat_key = -1;
        keys[9] = 1'b0;
        wait_release(100);

        // two columns low together on row 0
        s0 = n_strobe;
        keys[0] = 1'b1; keys[1] = 1'b1;
        repeat (60) step();
        check_eq("multi_strobes", n_strobe - s0, 32'd0);
        keys = 20'd0;
        repeat (4) step();

        // release with one bounce during HOLD
        keys[9] = 1'b1;
        wait_valid(100);
        s0 = n_strobe;
        keys[9] = 1'b0;
        pat_key = 9;
        pat_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        held_len = 1;
        for (int i = 0; i < 100 && key_held; i++) begin
            step();
            if (key_held) held_len++;
        end
        check_eq("held_len", held_len, 32'(6 * SD + 1));
        check_eq("release_strobes", n_strobe - s0, 32'd0);
        pat_key = -1;

        // reset in the middle of debounce
        keys[9] = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            step();
            if (m_phase == P_DEB) reached = 1'b1;
        end
        check_eq("reach_debounce", {31'd0, reached}, 32'd1);
        step();
        s0 = n_strobe;
        apply_reset();
        keys = 20'd0;
        repeat (30) step();
        check_eq("rst_no_strobe", n_strobe - s0, 32'd0);

        // randomized presses, multi-presses and glitches
        for (int it = 0; it < 40; it++) begin
            int hold_cyc;
            k = $urandom_range(19, 0);
            keys = 20'd0;
            keys[k] = 1'b1;
            if ($urandom_range(3, 0) == 0) keys[(k / 4) * 4 + $urandom_range(3, 0)] = 1'b1;
            hold_cyc = $urandom_range(70, 1);
            for (int j = 0; j < hold_cyc; j++) begin
                if ($urandom_range(15, 0) == 0) keys[k] = ~keys[k];
                step();
            end
            keys = 20'd0;
            repeat ($urandom_range(40, 1)) step();
        end

        // 256 clean presses: counter wraps 255 -> 0
        apply_reset();
        for (int p = 1; p <= 256; p++) begin
            k = $urandom_range(19, 0);
            keys[k] = 1'b1;
            wait_valid(120);
            check_eq("rand_code", {27'd0, key_code}, k);
            keys[k] = 1'b0;
            wait_release(120);
            if (p == 255) check_eq("cnt_255", {24'd0, press_cnt}, 32'd255);
            if (p == 256) check_eq("cnt_wrap", {24'd0, press_cnt}, 32'd0);
        end
        apply_reset();
        repeat (8) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
